// File: rtl/pixel_window_scheduler_pkg.sv
// Shared chip package for the pixel window scheduler.
// Holds the scheduler state encoding and the default frame geometry.
package pixel_window_scheduler_pkg;

    localparam int unsigned PWS_NUM_PX = 4;   // pixel addresses per frame
    localparam int unsigned PWS_NUM_CH = 5;   // counter channels per pixel
    localparam int unsigned PWS_SETTLE = 3;   // cycles from osc stop to first readout

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_INTEGRATE,
        ST_SETTLE,
        ST_READ,
        ST_NEXT
    } pws_state_t;

endpackage

// File: rtl/pixel_window_scheduler_window_timer.sv
// window_timer: loadable down-counter used for the integration window and the
// settle delay.
//   clk, clr_cntAcc : clock, async active-high reset
//   load, load_val  : load the counter with load_val (takes priority)
//   done            : high during the last counted cycle (count == 1)
module window_timer #(
    parameter int unsigned WIN_W = 23
) (
    input  logic             clk,
    input  logic             clr_cntAcc,
    input  logic             load,
    input  logic [WIN_W-1:0] load_val,
    output logic             done
);

    logic [WIN_W-1:0] cnt;

    always_ff @(posedge clk or posedge clr_cntAcc) begin
        if (clr_cntAcc) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIN_W'(1);
        end
    end

    assign done = (cnt == WIN_W'(1));

endmodule

// File: rtl/pixel_window_scheduler.sv
// pixel_window_scheduler: scans the enabled pixels of a frame; for each one it
// clears the counters, runs the oscillator for the integration window, waits
// for the counters to settle, then offers each channel for readout.
//   clk, clr_cntAcc   : clock, async active-high reset
//   start, cont       : frame start pulse, continuous (auto-restart) mode
//   win_len, px_mask  : integration window length, pixels to scan
//   ch_ack            : readout consumer accepted the offered channel
//   px_addr, en_osc, clr_counter : pixel counter control
//   ch_sel, ch_valid  : channel offered for readout
//   busy, frame_done  : frame in progress, one-cycle end-of-frame pulse
// All outputs are registered from the next-state decode.
module pixel_window_scheduler
    import pixel_window_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PX = PWS_NUM_PX,
    parameter int unsigned NUM_CH = PWS_NUM_CH,
    parameter int unsigned WIN_W  = 23,
    parameter int unsigned SETTLE = PWS_SETTLE
) (
    input  logic              clk,
    input  logic              clr_cntAcc,
    input  logic              start,
    input  logic              cont,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [NUM_PX-1:0] px_mask,
    input  logic              ch_ack,
    output logic [1:0]        px_addr,
    output logic              en_osc,
    output logic              clr_counter,
    output logic [2:0]        ch_sel,
    output logic              ch_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    pws_state_t        state, nxt_state;
    logic [NUM_PX-1:0] mask_q, mask_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [1:0]        px_addr_d;
    logic [2:0]        ch_sel_d;
    logic              ch_valid_d, en_osc_d, clr_counter_d, busy_d, frame_done_d;
    logic              tmr_load, tmr_done;
    logic [WIN_W-1:0]  tmr_val;
    logic              accept, last_ch;
    logic              nxt_found;
    logic [1:0]        nxt_bit;

    function automatic logic [1:0] low_bit(input logic [NUM_PX-1:0] m);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = NUM_PX; i > 0; i--) begin
            if (m[i-1]) idx = 2'(i - 1);
        end
        return idx;
    endfunction

    assign accept  = ch_valid & ch_ack;
    assign last_ch = (ch_sel == LAST_CH);

    // Lowest latched mask bit strictly above the current pixel.
    always_comb begin
        nxt_found = 1'b0;
        nxt_bit   = '0;
        for (int unsigned i = NUM_PX; i > 0; i--) begin
            if (mask_q[i-1] && ((i - 1) > 32'(px_addr))) begin
                nxt_found = 1'b1;
                nxt_bit   = 2'(i - 1);
            end
        end
    end

    // One timer serves both phases: loaded with the window during CLEAR and
    // reloaded with the settle delay on the last integrate cycle.
    assign tmr_load = (state == ST_CLEAR) || ((state == ST_INTEGRATE) && tmr_done);
    assign tmr_val  = (state == ST_CLEAR) ? ((win_q == '0) ? WIN_W'(1) : win_q)
                                          : WIN_W'(SETTLE);

    window_timer #(.WIN_W(WIN_W)) u_window_timer (
        .clk        (clk),
        .clr_cntAcc (clr_cntAcc),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .done       (tmr_done)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge clr_cntAcc) begin
        if (clr_cntAcc) begin
            state       <= ST_IDLE;
            mask_q      <= '0;
            win_q       <= '0;
            px_addr     <= '0;
            en_osc      <= 1'b0;
            clr_counter <= 1'b1;
            ch_sel      <= '0;
            ch_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= nxt_state;
            mask_q      <= mask_d;
            win_q       <= win_d;
            px_addr     <= px_addr_d;
            en_osc      <= en_osc_d;
            clr_counter <= clr_counter_d;
            ch_sel      <= ch_sel_d;
            ch_valid    <= ch_valid_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt_state = state;
        unique case (state)
            ST_IDLE:      if (start && (px_mask != '0)) nxt_state = ST_CLEAR;
            ST_CLEAR:     nxt_state = ST_INTEGRATE;
            ST_INTEGRATE: if (tmr_done) nxt_state = ST_SETTLE;
            ST_SETTLE:    if (tmr_done) nxt_state = ST_READ;
            ST_READ:      if (accept && last_ch) nxt_state = ST_NEXT;
            ST_NEXT:      nxt_state = (nxt_found || cont) ? ST_CLEAR : ST_IDLE;
            default:      nxt_state = ST_IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs).
    always_comb begin
        mask_d        = mask_q;
        win_d         = win_q;
        px_addr_d     = px_addr;
        ch_sel_d      = ch_sel;
        ch_valid_d    = ch_valid;
        frame_done_d  = 1'b0;
        en_osc_d      = (nxt_state == ST_INTEGRATE);
        clr_counter_d = (nxt_state == ST_CLEAR);
        busy_d        = (nxt_state != ST_IDLE);

        if (nxt_state == ST_CLEAR) win_d = win_len;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    mask_d       = px_mask;
                    px_addr_d    = low_bit(px_mask);
                    frame_done_d = (px_mask == '0);
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    ch_sel_d   = '0;
                    ch_valid_d = 1'b1;
                end
            end
            // Accept opens a one-cycle gap; the next channel is selected during
            // the gap so it is already stable when ch_valid returns.
            ST_READ: begin
                if (accept) begin
                    ch_valid_d = 1'b0;
                    ch_sel_d   = last_ch ? 3'd0 : ch_sel + 3'd1;
                end else if (!ch_valid) begin
                    ch_valid_d = 1'b1;
                end
            end
            ST_NEXT: begin
                if (nxt_found) begin
                    px_addr_d = nxt_bit;
                end else begin
                    frame_done_d = 1'b1;
                    if (cont) px_addr_d = low_bit(mask_q);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pixel_window_scheduler.sv
module tb_pixel_window_scheduler;

    logic       clk = 1'b0;
    logic       clr_cntAcc = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [22:0] win_len = '0;
    logic [3:0] px_mask = '0;
    logic       ch_ack = 1'b0;
    logic [1:0] px_addr;
    logic       en_osc, clr_counter, ch_valid, busy, frame_done;
    logic [2:0] ch_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_mode = 0;   // 0: ack follows valid, 1: ack held high

    // Monitor bookkeeping
    int runs[16];
    int run_px[16];
    int nruns, run, acc_cnt, fd_cnt, vrun, vmax, clr_cnt, exp_ch;

    pixel_window_scheduler #(
        .NUM_PX (4),
        .NUM_CH (5),
        .WIN_W  (23),
        .SETTLE (3)
    ) dut (
        .clk         (clk),
        .clr_cntAcc  (clr_cntAcc),
        .start       (start),
        .cont        (cont),
        .win_len     (win_len),
        .px_mask     (px_mask),
        .ch_ack      (ch_ack),
        .px_addr     (px_addr),
        .en_osc      (en_osc),
        .clr_counter (clr_counter),
        .ch_sel      (ch_sel),
        .ch_valid    (ch_valid),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        nruns = 0; run = 0; acc_cnt = 0; fd_cnt = 0;
        vrun = 0; vmax = 0; clr_cnt = 0; exp_ch = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int limit, input string tag);
        int n = 0;
        while (fd_cnt < target && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        if (fd_cnt < target) chk(tag, fd_cnt, target);
    endtask

    task automatic settle_idle(input int cyc);
        repeat (cyc) begin @(negedge clk); #1; end
    endtask

    // Readout consumer
    always @(posedge clk) begin
        #1;
        ch_ack = (ack_mode == 1) ? 1'b1 : ch_valid;
    end

    // Observation at the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!clr_cntAcc) begin
            if (en_osc) begin
                if (run == 0 && nruns < 16) run_px[nruns] = px_addr;
                run++;
            end else if (run != 0) begin
                if (nruns < 16) runs[nruns] = run;
                nruns++;
                run = 0;
            end
            if (ch_valid && ch_ack) begin
                acc_cnt++;
                chk("ch_sel_order", 32'(ch_sel), exp_ch);
                exp_ch = (exp_ch == 4) ? 0 : exp_ch + 1;
            end
            if (ch_valid) vrun++; else vrun = 0;
            if (vrun > vmax) vmax = vrun;
            if (frame_done) fd_cnt++;
            if (clr_counter) clr_cnt++;
        end
    end

    initial begin
        int fd_before;
        int n;
        clear_counts();

        // Reset values
        #1 clr_cntAcc = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_px_addr", 32'(px_addr), 0);
        chk("rst_en_osc", 32'(en_osc), 0);
        chk("rst_clr_counter", 32'(clr_counter), 1);
        chk("rst_ch_sel", 32'(ch_sel), 0);
        chk("rst_ch_valid", 32'(ch_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        clr_cntAcc = 1'b0;
        @(negedge clk); #1;
        chk("rel_clr_counter", 32'(clr_counter), 0);
        chk("rel_busy", 32'(busy), 0);

        // Full mask, window 10, start re-pulsed mid-frame (ignored)
        clear_counts();
        px_mask = 4'b1111; win_len = 23'd10; cont = 1'b0; ack_mode = 0;
        pulse_start();
        settle_idle(30);
        pulse_start();
        wait_fd(1, 400, "t1_timeout");
        settle_idle(5);
        chk("t1_runs", nruns, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_run_len", runs[i], 10);
            chk("t1_run_px", run_px[i], i);
        end
        chk("t1_acks", acc_cnt, 20);
        chk("t1_frames", fd_cnt, 1);
        chk("t1_clears", clr_cnt, 4);
        chk("t1_busy_end", 32'(busy), 0);

        // Sparse mask; win_len changed during the first window only affects px 2
        clear_counts();
        px_mask = 4'b0101; win_len = 23'd10;
        pulse_start();
        settle_idle(5);
        win_len = 23'd3;
        wait_fd(1, 300, "t2_timeout");
        settle_idle(5);
        chk("t2_runs", nruns, 2);
        chk("t2_px0", run_px[0], 0);
        chk("t2_len0", runs[0], 10);
        chk("t2_px2", run_px[1], 2);
        chk("t2_len2", runs[1], 3);
        chk("t2_acks", acc_cnt, 10);
        chk("t2_frames", fd_cnt, 1);

        // win_len=0 behaves as 1; ack held high through READ
        clear_counts();
        px_mask = 4'b0001; win_len = 23'd0; ack_mode = 1;
        pulse_start();
        wait_fd(1, 200, "t3_timeout");
        settle_idle(5);
        chk("t3_runs", nruns, 1);
        chk("t3_len", runs[0], 1);
        chk("t3_acks", acc_cnt, 5);
        chk("t3_valid_run", vmax, 1);
        chk("t3_frames", fd_cnt, 1);
        ack_mode = 0;
        settle_idle(2);

        // Empty mask
        clear_counts();
        px_mask = 4'b0000; win_len = 23'd4;
        pulse_start();
        @(negedge clk); #1;
        chk("t4_fd_pulse", 32'(frame_done), 1);
        chk("t4_busy", 32'(busy), 0);
        @(negedge clk); #1;
        chk("t4_fd_end", 32'(frame_done), 0);
        chk("t4_busy2", 32'(busy), 0);
        chk("t4_runs", nruns, 0);

        // Continuous single pixel, then cont dropped
        clear_counts();
        px_mask = 4'b1000; win_len = 23'd2; cont = 1'b1;
        pulse_start();
        wait_fd(3, 300, "t5_timeout");
        cont = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); #1; n++; end
        chk("t5_idle", 32'(busy), 0);
        settle_idle(5);
        chk("t5_frames", fd_cnt, 4);
        chk("t5_runs", nruns, 4);
        for (int i = 0; i < 4; i++) chk("t5_px", run_px[i], 3);
        chk("t5_len", runs[0], 2);
        chk("t5_acks", acc_cnt, 20);

        // Reset during integrate of pixel 2
        clear_counts();
        px_mask = 4'b1111; win_len = 23'd10;
        pulse_start();
        n = 0;
        while (!(en_osc && px_addr == 2'd2) && n < 300) begin @(negedge clk); #1; n++; end
        chk("t6_reach_px2", 32'(px_addr), 2);
        fd_before = fd_cnt;
        clr_cntAcc = 1'b1;
        #1;
        chk("t6_px_addr", 32'(px_addr), 0);
        chk("t6_en_osc", 32'(en_osc), 0);
        chk("t6_clr_counter", 32'(clr_counter), 1);
        chk("t6_ch_valid", 32'(ch_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_frame_done", 32'(frame_done), 0);
        @(negedge clk); #1;
        chk("t6_no_fd", fd_cnt, fd_before);
        clr_cntAcc = 1'b0;
        clear_counts();
        pulse_start();
        n = 0;
        while (!en_osc && n < 50) begin @(negedge clk); #1; n++; end
        chk("t6_restart_osc", 32'(en_osc), 1);
        chk("t6_restart_px", 32'(px_addr), 0);
        wait_fd(1, 400, "t6_timeout");
        settle_idle(5);
        chk("t6_runs", nruns, 4);
        chk("t6_acks", acc_cnt, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
